tone_square_gen: RTL

Audio back end for the note lookup: converts the 32-bit tone frequency word (Hz) produced by the note-index decoder into a 1-bit square wave on the speaker pin. The half-period is derived at run time with an iterative restoring divider. Tone changes are applied glitch-free at a waveform edge. The silence code and out-of-range tones mute the output.

---
 rtl/tone_square_gen.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/tone_square_gen.sv
// Square-wave tone generator: frequency word (Hz) -> half-period via iterative restoring divider.
// Optional macro TONE_SQUARE_GEN_VOLUME_EN adds a 3-bit PWM volume gate on the output.
module tone_square_gen #(
  parameter int unsigned CLK_HZ     = 100_000_000,
  parameter int unsigned SILENCE_HZ = 20000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] tone,
`ifdef TONE_SQUARE_GEN_VOLUME_EN
  input  logic [2:0]  vol,
`endif
  output logic        audio_out,
  output logic        busy,
  output logic [31:0] half_period
);

  localparam logic [1:0] S_MUTE = 2'd0;
  localparam logic [1:0] S_DIV  = 2'd1;
  localparam logic [1:0] S_RUN  = 2'd2;

  logic [1:0]  state;
  logic [31:0] tone_q;
  logic        chg_q;
  logic [33:0] rem;
  logic [31:0] quot;
  logic [32:0] divisor;
  logic [4:0]  iter;
  logic        from_run;
  logic        square;
  logic [31:0] cnt;
  logic [31:0] pend;
  logic        pend_vld;

  logic        tone_mute;
  logic [33:0] trial;
  logic        trial_ge;
  logic [33:0] rem_nxt;
  logic [31:0] quot_nxt;
  logic        run_active;
  logic        toggle;

  // quot doubles as the dividend shift register: dividend bits leave the top, quotient bits enter the bottom
  assign tone_mute  = (tone_q == 32'd0) || (tone_q >= SILENCE_HZ);
  assign trial      = {rem[32:0], quot[31]};
  assign trial_ge   = trial >= {1'b0, divisor};
  assign rem_nxt    = trial_ge ? (trial - {1'b0, divisor}) : trial;
  assign quot_nxt   = {quot[30:0], trial_ge};
  assign run_active = (state == S_RUN) || ((state == S_DIV) && from_run);
  assign toggle     = run_active && (cnt == half_period - 32'd1);
  assign busy       = (state == S_DIV);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_MUTE;
      tone_q      <= SILENCE_HZ;
      chg_q       <= 1'b0;
      rem         <= '0;
      quot        <= '0;
      divisor     <= '0;
      iter        <= '0;
      from_run    <= 1'b0;
      square      <= 1'b0;
      cnt         <= '0;
      half_period <= '0;
      pend        <= '0;
      pend_vld    <= 1'b0;
    end else begin
      tone_q <= tone;
      chg_q  <= (tone != tone_q);

      // The current waveform keeps running while a replacement period is being computed
      if (run_active) begin
        if (toggle) begin
          square <= ~square;
          cnt    <= '0;
          if (pend_vld) begin
            half_period <= pend;
            pend_vld    <= 1'b0;
          end
        end else begin
          cnt <= cnt + 32'd1;
        end
      end

      if (chg_q && tone_mute) begin
        state       <= S_MUTE;
        square      <= 1'b0;
        cnt         <= '0;
        half_period <= '0;
        pend_vld    <= 1'b0;
      end else if (chg_q) begin
        state   <= S_DIV;
        rem     <= '0;
        quot    <= CLK_HZ;
        divisor <= {tone_q, 1'b0};
        iter    <= '0;
        if (state == S_RUN)
          from_run <= 1'b1;
        else if (state == S_MUTE)
          from_run <= 1'b0;
      end else if (state == S_DIV) begin
        rem  <= rem_nxt;
        quot <= quot_nxt;
        iter <= iter + 5'd1;
        if (iter == 5'd31) begin
          if (quot_nxt == 32'd0) begin
            state       <= S_MUTE;
            square      <= 1'b0;
            cnt         <= '0;
            half_period <= '0;
            pend_vld    <= 1'b0;
          end else if (from_run) begin
            // Written after the toggle logic so a coincident toggle leaves this value pending
            pend     <= quot_nxt;
            pend_vld <= 1'b1;
            state    <= S_RUN;
          end else begin
            half_period <= quot_nxt;
            cnt         <= '0;
            square      <= 1'b0;
            state       <= S_RUN;
          end
        end
      end
    end
  end

`ifdef TONE_SQUARE_GEN_VOLUME_EN
  logic [2:0] pwm_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) pwm_cnt <= '0;
    else     pwm_cnt <= pwm_cnt + 3'd1;
  end

  assign audio_out = square & (pwm_cnt < vol);
`else
  assign audio_out = square;
`endif

endmodule
